uc_microc: RTL and testbench
============================

// Module: uc_microc
// PURPOSE
//  Control unit for the single-cycle microcontroller datapath without data memory. Decodes the 6-bit opcode
//  (instruction[15:10]) into the datapath controls each cycle. Holds the architectural zero flag and a
//  hardware return-address stack, which add jump-and-link and return to the datapath's jump.
//  Sits directly beside the datapath. It consumes opcode, the ALU zero output and PC+1. It drives the
//  write enables, the ALU operation, the immediate mux select, the PC source select and the return address.
// PARAMETERS
//  DEPTH  4   return-stack entries (power of 2, >=2)
//  AW     10  PC / stack-entry width
// PORTS
//  clk       in   1     rising-edge clock
//  reset     in   1     synchronous, active-high
//  opcode    in   6     instruction[15:10] from datapath
//  z_alu     in   1     combinational ALU zero output
//  pc_plus1  in   AW    output of PC+1 adder (return address for JAL)
//  s_pc      out  2     PC source: 00 PC+1, 01 instruction[9:0], 10 ret_addr
//  s_inm     out  1     1: register write data = instruction[11:4]
//  we3       out  1     register-file write enable
//  wez       out  1     zero-flag update enable (exported for observation)
//  op        out  3     ALU operation
//  ret_addr  out  AW    top-of-stack entry; 0 when stack empty
//  z_flag    out  1     registered zero flag
//  sp        out  $clog2(DEPTH)+1  current stack occupancy
//  stk_ovf   out  1     sticky: push attempted while full
//  stk_unf   out  1     sticky: pop attempted while empty
//  illegal   out  1     high while the current opcode is undefined
// BEHAVIOUR
//  - Decode is combinational on the current opcode. Stack, z_flag and sticky flags update on the clk rising edge.
//  - Opcode table (unlisted opcodes give all enables 0, s_pc=00, illegal=1; they act as NOP):
//      000000 NOP  : no writes, s_pc=00
//      0001xx LI   : we3=1, s_inm=1, wez=0, s_pc=00
//      001ooo ALU  : op=ooo, we3=1, wez=1, s_inm=0, s_pc=00
//      010000 J    : s_pc=01
//      010001 JZ   : s_pc = z_flag ? 01 : 00
//      010010 JNZ  : s_pc = z_flag ? 00 : 01
//      010011 JAL  : push pc_plus1, s_pc=01
//      010100 RET  : pop, s_pc=10 (00 if stack empty)
//  - op defaults to 000 when the opcode is not an ALU opcode. we3/wez/s_inm are 0 for jumps.
//  - z_flag <= z_alu at the edge when wez=1. Otherwise z_flag holds. JZ/JNZ test the registered flag, so
//    an ALU result is visible to a branch in the next instruction.
//  - Stack: LIFO, entries AW bits wide. Push writes entry[sp] and sets sp+1. Pop sets sp-1.
//    ret_addr = entry[sp-1] combinationally, so RET jumps in the same cycle that it pops.
//  - Full + JAL: the jump still happens, the push is dropped, sp is unchanged and stk_ovf is set.
//  - Empty + RET: s_pc=00 (falls through), sp stays 0, stk_unf is set.
//  - stk_ovf/stk_unf stay set until reset.
//  - Reset while reset=1, with priority over every event:
//      z_flag=0, sp=0, ret_addr=0, stk_ovf=0, stk_unf=0.
//      Outputs forced safe: we3=0, wez=0, s_inm=0, s_pc=00, op=000.
//      Stack contents need not be cleared, because they are unreachable when sp=0.
//    Reset asserted mid-program discards all pending stack state.
//  - A push or pop is never simultaneous with another stack operation (single instruction per cycle).
//  - No latency beyond the single cycle. No stalls or handshakes.
// TESTING
//  1 Reset: hold reset 2 cycles with opcode=001000 -> we3=0, wez=0, s_pc=00, z_flag=0, sp=0. Release -> we3=1, wez=1.
//  2 Flag: ALU op with z_alu=1, then JZ -> s_pc=01. ALU op with z_alu=0, then JNZ -> s_pc=01.
//    LI between them leaves z_flag unchanged.
//  3 Call/return: JAL with pc_plus1=10'h005, then JAL with pc_plus1=10'h020 -> sp=2.
//    RET -> ret_addr=10'h020, s_pc=10, sp=1. RET -> ret_addr=10'h005, sp=0.
//  4 Overflow: 5 JALs at DEPTH=4 -> sp=4, stk_ovf=1, s_pc=01 on the 5th.
//    4 RETs return the first four addresses in reverse order.
//  5 Underflow: RET with sp=0 -> s_pc=00, sp=0, stk_unf=1. Reset clears stk_unf.
//  6 Illegal: opcode=111111 -> illegal=1, all enables 0, s_pc=00. State unchanged next cycle.

Source files
------------

// File: rtl/uc_microc_if.sv
// ---------------------------------------------------------------------------
// uc_microc_if
//   Bundle between the single-cycle datapath and its control unit.
//   master : datapath side. Drives opcode, z_alu and pc_plus1, and receives
//            the decoded controls, the return address and the status outputs.
//   slave  : control-unit side (uc_microc).
//   Signals
//     opcode   [5:0]      instruction[15:10]
//     z_alu               combinational ALU zero output
//     pc_plus1 [AW-1:0]   PC+1, the return address pushed by JAL
//     s_pc     [1:0]      PC source: 00 PC+1, 01 instruction[9:0], 10 ret_addr
//     s_inm               register write data = instruction[11:4]
//     we3                 register-file write enable
//     wez                 zero-flag update enable
//     op       [2:0]      ALU operation
//     ret_addr [AW-1:0]   top of the return stack (0 when empty)
//     z_flag              registered zero flag
//     sp                  return-stack occupancy
//     stk_ovf / stk_unf   sticky overflow / underflow flags
//     illegal             current opcode is undefined
// ---------------------------------------------------------------------------
interface uc_microc_if #(
    parameter int DEPTH = 4,
    parameter int AW    = 10
);
    logic [5:0]              opcode;
    logic                    z_alu;
    logic [AW-1:0]           pc_plus1;
    logic [1:0]              s_pc;
    logic                    s_inm;
    logic                    we3;
    logic                    wez;
    logic [2:0]              op;
    logic [AW-1:0]           ret_addr;
    logic                    z_flag;
    logic [$clog2(DEPTH):0]  sp;
    logic                    stk_ovf;
    logic                    stk_unf;
    logic                    illegal;

    modport master (
        output opcode, z_alu, pc_plus1,
        input  s_pc, s_inm, we3, wez, op, ret_addr, z_flag, sp,
               stk_ovf, stk_unf, illegal
    );

    modport slave (
        input  opcode, z_alu, pc_plus1,
        output s_pc, s_inm, we3, wez, op, ret_addr, z_flag, sp,
               stk_ovf, stk_unf, illegal
    );
endinterface

// File: rtl/uc_microc.sv
// ---------------------------------------------------------------------------
// uc_microc
//   Control unit for the single-cycle microcontroller datapath. Decodes the
//   opcode combinationally into datapath controls, holds the zero flag and a
//   return-address stack that adds JAL / RET to the datapath's jump.
//   Ports
//     clk    rising-edge clock
//     reset  synchronous, active-high; forces safe controls while asserted
//     bus    uc_microc_if.slave (opcode, z_alu, pc_plus1 in; controls,
//            ret_addr, z_flag, sp, stk_ovf, stk_unf, illegal out)
// ---------------------------------------------------------------------------
module uc_microc #(
    parameter int DEPTH = 4,
    parameter int AW    = 10
) (
    input  logic        clk,
    input  logic        reset,
    uc_microc_if.slave  bus
);
    localparam int AI  = $clog2(DEPTH);
    localparam int SPW = AI + 1;

    logic [AW-1:0]  stack_mem [DEPTH];
    logic [SPW-1:0] sp_q;
    logic           z_q;
    logic           ovf_q;
    logic           unf_q;

    logic           stk_empty;
    logic           stk_full;
    logic [AI-1:0]  top_idx;

    logic [1:0]     s_pc_d;
    logic           we3_d;
    logic           wez_d;
    logic           inm_d;
    logic [2:0]     op_d;
    logic           ill_d;
    logic           is_jal;
    logic           is_ret;

    assign stk_empty = (sp_q == '0);
    assign stk_full  = (sp_q == SPW'(DEPTH));
    // When full, sp[AI-1:0] wraps to 0, so subtracting one still lands on
    // the last entry.
    assign top_idx   = sp_q[AI-1:0] - AI'(1);

    always_comb begin
        s_pc_d = 2'b00;
        we3_d  = 1'b0;
        wez_d  = 1'b0;
        inm_d  = 1'b0;
        op_d   = 3'b000;
        ill_d  = 1'b0;
        is_jal = 1'b0;
        is_ret = 1'b0;
        casez (bus.opcode)
            6'b000000: ;
            6'b0001??: begin
                we3_d = 1'b1;
                inm_d = 1'b1;
            end
            6'b001???: begin
                we3_d = 1'b1;
                wez_d = 1'b1;
                op_d  = bus.opcode[2:0];
            end
            6'b010000: s_pc_d = 2'b01;
            6'b010001: s_pc_d = z_q ? 2'b01 : 2'b00;
            6'b010010: s_pc_d = z_q ? 2'b00 : 2'b01;
            6'b010011: begin
                is_jal = 1'b1;
                s_pc_d = 2'b01;
            end
            6'b010100: begin
                is_ret = 1'b1;
                s_pc_d = stk_empty ? 2'b00 : 2'b10;
            end
            default:   ill_d = 1'b1;
        endcase
    end

    assign bus.s_pc     = reset ? 2'b00 : s_pc_d;
    assign bus.we3      = reset ? 1'b0  : we3_d;
    assign bus.wez      = reset ? 1'b0  : wez_d;
    assign bus.s_inm    = reset ? 1'b0  : inm_d;
    assign bus.op       = reset ? 3'b000 : op_d;
    assign bus.illegal  = ill_d;
    assign bus.ret_addr = (reset || stk_empty) ? '0 : stack_mem[top_idx];
    assign bus.z_flag   = z_q;
    assign bus.sp       = sp_q;
    assign bus.stk_ovf  = ovf_q;
    assign bus.stk_unf  = unf_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            z_q   <= 1'b0;
            sp_q  <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (wez_d)
                z_q <= bus.z_alu;
            if (is_jal) begin
                if (stk_full)
                    ovf_q <= 1'b1;
                else
                    sp_q <= sp_q + SPW'(1);
            end
            if (is_ret) begin
                if (stk_empty)
                    unf_q <= 1'b1;
                else
                    sp_q <= sp_q - SPW'(1);
            end
        end
    end

    // Entries are left uncleared: with sp=0 nothing can read them.
    always_ff @(posedge clk) begin
        if (!reset && is_jal && !stk_full)
            stack_mem[sp_q[AI-1:0]] <= bus.pc_plus1;
    end
endmodule

// File: tb/tb_uc_microc.sv
// ---------------------------------------------------------------------------
// tb_uc_microc
//   Table of {inputs, expected outputs} records applied one per cycle, plus
//   a generated call/return sequence with random return addresses. Each
//   applied record is queued and compared on the following falling edge.
// ---------------------------------------------------------------------------
module tb_uc_microc;
    localparam int DEPTH = 4;
    localparam int AW    = 10;

    localparam logic [5:0] NOP = 6'b000000;
    localparam logic [5:0] LI  = 6'b000100;
    localparam logic [5:0] ALU = 6'b001000;
    localparam logic [5:0] JZ  = 6'b010001;
    localparam logic [5:0] JNZ = 6'b010010;
    localparam logic [5:0] JAL = 6'b010011;
    localparam logic [5:0] RET = 6'b010100;

    typedef struct {
        logic        rst;
        logic [5:0]  opc;
        logic        z;
        logic [9:0]  pcp1;
        logic [1:0]  s_pc;
        logic        we3;
        logic        wez;
        logic        inm;
        logic [2:0]  op;
        logic [9:0]  ret;
        logic        zf;
        logic [2:0]  sp;
        logic        ovf;
        logic        unf;
        logic        ill;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    uc_microc_if #(.DEPTH(DEPTH), .AW(AW)) bus ();
    uc_microc #(.DEPTH(DEPTH), .AW(AW)) dut (.clk(clk), .reset(reset), .bus(bus));

    vec_t tbl [$];
    vec_t exp_q [$];
    int   n_vec  = 0;
    int   n_miss = 0;
    logic [9:0] addrs [DEPTH+1];

    function automatic vec_t mk(logic rst, logic [5:0] opc, logic z, logic [9:0] pcp1,
                                logic [1:0] s_pc, logic we3, logic wez, logic inm,
                                logic [2:0] op, logic [9:0] ret, logic zf, logic [2:0] sp,
                                logic ovf, logic unf, logic ill);
        vec_t v;
        v.rst = rst; v.opc = opc; v.z = z; v.pcp1 = pcp1;
        v.s_pc = s_pc; v.we3 = we3; v.wez = wez; v.inm = inm; v.op = op;
        v.ret = ret; v.zf = zf; v.sp = sp; v.ovf = ovf; v.unf = unf; v.ill = ill;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        @(posedge clk);
        #1;
        reset        = v.rst;
        bus.opcode   = v.opc;
        bus.z_alu    = v.z;
        bus.pc_plus1 = v.pcp1;
        exp_q.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [9:0] act,
                       input logic [9:0] exp);
        if (act !== exp) begin
            n_miss++;
            $display("FAIL vec %0d %s: got %h expected %h", idx, name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            vec_t e;
            e = exp_q.pop_front();
            chk("s_pc",     n_vec, 10'(bus.s_pc),    10'(e.s_pc));
            chk("we3",      n_vec, 10'(bus.we3),     10'(e.we3));
            chk("wez",      n_vec, 10'(bus.wez),     10'(e.wez));
            chk("s_inm",    n_vec, 10'(bus.s_inm),   10'(e.inm));
            chk("op",       n_vec, 10'(bus.op),      10'(e.op));
            chk("ret_addr", n_vec, bus.ret_addr,     e.ret);
            chk("z_flag",   n_vec, 10'(bus.z_flag),  10'(e.zf));
            chk("sp",       n_vec, 10'(bus.sp),      10'(e.sp));
            chk("stk_ovf",  n_vec, 10'(bus.stk_ovf), 10'(e.ovf));
            chk("stk_unf",  n_vec, 10'(bus.stk_unf), 10'(e.unf));
            chk("illegal",  n_vec, 10'(bus.illegal), 10'(e.ill));
            n_vec++;
        end
    end

    initial begin
        //            rst opc     z  pcp1     s_pc we3 wez inm op    ret      zf sp ovf unf ill
        // reset held two cycles on an ALU opcode, then released
        tbl.push_back(mk(1, ALU,  0, 10'h000, 2'b00, 0, 0, 0, 3'd0, 10'h000, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, ALU,  0, 10'h000, 2'b00, 0, 0, 0, 3'd0, 10'h000, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, ALU,  1, 10'h000, 2'b00, 1, 1, 0, 3'd0, 10'h000, 0, 0, 0, 0, 0));
        // flag: LI keeps it, JZ taken, ALU clears it, LI keeps it, JNZ taken, JZ not
        tbl.push_back(mk(0, LI,   0, 10'h000, 2'b00, 1, 0, 1, 3'd0, 10'h000, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, JZ,   0, 10'h000, 2'b01, 0, 0, 0, 3'd0, 10'h000, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 6'b001101, 0, 10'h000, 2'b00, 1, 1, 0, 3'd5, 10'h000, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 6'b000111, 1, 10'h000, 2'b00, 1, 0, 1, 3'd0, 10'h000, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, JNZ,  0, 10'h000, 2'b01, 0, 0, 0, 3'd0, 10'h000, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, JZ,   0, 10'h000, 2'b00, 0, 0, 0, 3'd0, 10'h000, 0, 0, 0, 0, 0));
        // call / return
        tbl.push_back(mk(0, JAL,  0, 10'h005, 2'b01, 0, 0, 0, 3'd0, 10'h000, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, JAL,  0, 10'h020, 2'b01, 0, 0, 0, 3'd0, 10'h005, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, RET,  0, 10'h000, 2'b10, 0, 0, 0, 3'd0, 10'h020, 0, 2, 0, 0, 0));
        tbl.push_back(mk(0, RET,  0, 10'h000, 2'b10, 0, 0, 0, 3'd0, 10'h005, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, NOP,  0, 10'h000, 2'b00, 0, 0, 0, 3'd0, 10'h000, 0, 0, 0, 0, 0));
        // overflow: five calls, four returns
        tbl.push_back(mk(0, JAL,  0, 10'h101, 2'b01, 0, 0, 0, 3'd0, 10'h000, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, JAL,  0, 10'h102, 2'b01, 0, 0, 0, 3'd0, 10'h101, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, JAL,  0, 10'h103, 2'b01, 0, 0, 0, 3'd0, 10'h102, 0, 2, 0, 0, 0));
        tbl.push_back(mk(0, JAL,  0, 10'h104, 2'b01, 0, 0, 0, 3'd0, 10'h103, 0, 3, 0, 0, 0));
        tbl.push_back(mk(0, JAL,  0, 10'h105, 2'b01, 0, 0, 0, 3'd0, 10'h104, 0, 4, 0, 0, 0));
        tbl.push_back(mk(0, RET,  0, 10'h000, 2'b10, 0, 0, 0, 3'd0, 10'h104, 0, 4, 1, 0, 0));
        tbl.push_back(mk(0, RET,  0, 10'h000, 2'b10, 0, 0, 0, 3'd0, 10'h103, 0, 3, 1, 0, 0));
        tbl.push_back(mk(0, RET,  0, 10'h000, 2'b10, 0, 0, 0, 3'd0, 10'h102, 0, 2, 1, 0, 0));
        tbl.push_back(mk(0, RET,  0, 10'h000, 2'b10, 0, 0, 0, 3'd0, 10'h101, 0, 1, 1, 0, 0));
        // underflow, then reset clears both sticky flags
        tbl.push_back(mk(0, RET,  0, 10'h000, 2'b00, 0, 0, 0, 3'd0, 10'h000, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, NOP,  0, 10'h000, 2'b00, 0, 0, 0, 3'd0, 10'h000, 0, 0, 1, 1, 0));
        tbl.push_back(mk(1, NOP,  0, 10'h000, 2'b00, 0, 0, 0, 3'd0, 10'h000, 0, 0, 1, 1, 0));
        tbl.push_back(mk(0, NOP,  0, 10'h000, 2'b00, 0, 0, 0, 3'd0, 10'h000, 0, 0, 0, 0, 0));
        // illegal opcodes leave the flag and the stack alone
        tbl.push_back(mk(0, ALU,  1, 10'h000, 2'b00, 1, 1, 0, 3'd0, 10'h000, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 6'b111111, 0, 10'h3AA, 2'b00, 0, 0, 0, 3'd0, 10'h000, 1, 0, 0, 0, 1));
        tbl.push_back(mk(0, 6'b010101, 0, 10'h3AA, 2'b00, 0, 0, 0, 3'd0, 10'h000, 1, 0, 0, 0, 1));
        tbl.push_back(mk(0, NOP,  0, 10'h000, 2'b00, 0, 0, 0, 3'd0, 10'h000, 1, 0, 0, 0, 0));
        // reset mid-program drops the stacked call and blocks a JAL
        tbl.push_back(mk(0, JAL,  0, 10'h3FF, 2'b01, 0, 0, 0, 3'd0, 10'h000, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, JAL,  0, 10'h111, 2'b00, 0, 0, 0, 3'd0, 10'h000, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, RET,  0, 10'h000, 2'b00, 0, 0, 0, 3'd0, 10'h000, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, NOP,  0, 10'h000, 2'b00, 0, 0, 0, 3'd0, 10'h000, 0, 0, 0, 1, 0));

        reset        = 1'b1;
        bus.opcode   = ALU;
        bus.z_alu    = 1'b0;
        bus.pc_plus1 = '0;
        @(posedge clk);

        for (int i = 0; i < tbl.size(); i++)
            drive(tbl[i]);

        // Generated sequence: reset, DEPTH+1 calls with random return
        // addresses, then DEPTH returns in reverse order.
        drive(mk(1, NOP, 0, 10'h000, 2'b00, 0, 0, 0, 3'd0, 10'h000, 0, 0, 0, 1, 0));
        for (int i = 0; i <= DEPTH; i++) begin
            addrs[i] = 10'($urandom_range(1, 1023));
            drive(mk(0, JAL, 0, addrs[i], 2'b01, 0, 0, 0, 3'd0,
                     (i == 0) ? 10'h000 : addrs[i-1], 0,
                     3'((i < DEPTH) ? i : DEPTH), 0, 0, 0));
        end
        for (int k = 0; k < DEPTH; k++)
            drive(mk(0, RET, 0, 10'h000, 2'b10, 0, 0, 0, 3'd0, addrs[DEPTH-1-k], 0,
                     3'(DEPTH - k), 1, 0, 0));
        drive(mk(0, NOP, 0, 10'h000, 2'b00, 0, 0, 0, 3'd0, 10'h000, 0, 0, 1, 0, 0));

        repeat (2) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL drain: %0d records left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
